// File: rtl/gate_chk_pkg.sv
// ============================================================================
//  gate_chk_pkg
//  Shared encodings for the two-input gate truth-table checker.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package gate_chk_pkg;

  // Number of truth-table vectors applied per run; vector i = {a,b} = i.
  localparam int NUM_VEC = 4;

  // Encoding of gate_sel.
  typedef enum logic [2:0] {
    GATE_AND   = 3'd0,
    GATE_OR    = 3'd1,
    GATE_NAND  = 3'd2,
    GATE_NOR   = 3'd3,
    GATE_XOR   = 3'd4,
    GATE_XNOR  = 3'd5,
    GATE_BUF_A = 3'd6,
    GATE_NOT_A = 3'd7
  } gate_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/gate_ref_model.sv
// ============================================================================
//  gate_ref_model
//  Combinational reference: expected gate output for a selected function.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module gate_ref_model
  import gate_chk_pkg::*;
(
  input  logic [2:0] sel,
  input  logic       a,
  input  logic       b,
  output logic       expected
);

  always_comb begin
    expected = 1'b0;
    case (gate_sel_e'(sel))
      GATE_AND:   expected = a & b;
      GATE_OR:    expected = a | b;
      GATE_NAND:  expected = ~(a & b);
      GATE_NOR:   expected = ~(a | b);
      GATE_XOR:   expected = a ^ b;
      GATE_XNOR:  expected = ~(a ^ b);
      GATE_BUF_A: expected = a;
      GATE_NOT_A: expected = ~a;
      default:    expected = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/gate_truth_checker.sv
// ============================================================================
//  gate_truth_checker
//  Walks a two-input gate through all four input vectors and records mismatches.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module gate_truth_checker
  import gate_chk_pkg::*;
#(
  parameter int SETTLE_CYC = 2   // legal range 1..15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] gate_sel,
  output logic       a,
  output logic       b,
  input  logic       f,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_mask
);

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [1:0] IDX_LAST = 2'(NUM_VEC - 1);

  state_e     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [2:0] err_q, err_d;
  logic [3:0] mask_q, mask_d;

  logic       expected;
  logic       mismatch;
  logic [1:0] idx_next;

  gate_ref_model u_ref (
    .sel      (sel_q),
    .a        (a_q),
    .b        (b_q),
    .expected (expected)
  );

  assign mismatch = f ^ expected;
  assign idx_next = idx_q + 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= 3'd0;
      idx_q   <= 2'd0;
      cnt_q   <= 4'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 3'd0;
      mask_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    mask_d  = mask_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sel_d   = gate_sel;
          err_d   = 3'd0;
          mask_d  = 4'd0;
          pass_d  = 1'b0;
          idx_d   = 2'd0;
          cnt_d   = 4'd0;
          a_d     = 1'b0;
          b_d     = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_DRIVE;
        end
      end

      ST_DRIVE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = 4'd0;
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      ST_SAMPLE: begin
        if (mismatch) begin
          mask_d[idx_q] = 1'b1;
          err_d         = err_q + 3'd1;
        end
        if (idx_q != IDX_LAST) begin
          // Operands follow the vector index, so they only move on DRIVE entry.
          idx_d      = idx_next;
          {a_d, b_d} = idx_next;
          cnt_d      = 4'd0;
          state_d    = ST_DRIVE;
        end else begin
          pass_d  = (mask_d == 4'd0);
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_mask = mask_q;

endmodule

`default_nettype wire

// File: tb/tb_gate_truth_checker.sv
// ============================================================================
//  tb_gate_truth_checker
//  Checks the truth checker against truth-table arithmetic with injected faults.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_gate_truth_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance 0 settles 2 cycles, instance 1 settles 1 cycle.
  logic       start0 = 1'b0, start1 = 1'b0;
  logic [2:0] sel0 = 3'd0, sel1 = 3'd0;
  logic [3:0] gut0 = 4'd0, gut1 = 4'd0;   // truth table of the gate under test
  logic       a0, b0, f0, busy0, done0, pass0;
  logic       a1, b1, f1, busy1, done1, pass1;
  logic [2:0] err0, err1;
  logic [3:0] mask0, mask1;

  assign f0 = gut0[{a0, b0}];
  assign f1 = gut1[{a1, b1}];

  gate_truth_checker #(.SETTLE_CYC(2)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .gate_sel(sel0), .a(a0), .b(b0), .f(f0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_mask(mask0));

  gate_truth_checker #(.SETTLE_CYC(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .gate_sel(sel1), .a(a1), .b(b1), .f(f1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_mask(mask1));

  int cur = 0;
  logic       o_a, o_b, o_busy, o_done, o_pass;
  logic [2:0] o_err;
  logic [3:0] o_mask;
  always_comb begin
    o_a = cur ? a1 : a0;         o_b = cur ? b1 : b0;
    o_busy = cur ? busy1 : busy0; o_done = cur ? done1 : done0;
    o_pass = cur ? pass1 : pass0; o_err = cur ? err1 : err0;
    o_mask = cur ? mask1 : mask0;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Bit i of the result is the gate output for {a,b} = i.
  function automatic logic [3:0] truth(input logic [2:0] s);
    case (s)
      3'd0: return 4'b1000;
      3'd1: return 4'b1110;
      3'd2: return 4'b0111;
      3'd3: return 4'b0001;
      3'd4: return 4'b0110;
      3'd5: return 4'b1001;
      3'd6: return 4'b1100;
      default: return 4'b0011;
    endcase
  endfunction

  function automatic int popcount(input logic [3:0] v);
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic set_start(input int which, input logic v);
    if (which == 1) start1 = v; else start0 = v;
  endtask

  task automatic run(input int which, input logic [2:0] sel, input logic [3:0] gut,
                     input int exp_pass, input int exp_err, input int exp_mask,
                     input int restart_cyc);
    int settle   = (which == 1) ? 1 : 2;
    int exp_done = 4 * (settle + 1) + 1;
    int done_n   = 0;
    int done_cyc = 0;
    int ab_bad   = 0;
    cur = which;
    @(negedge clk);
    if (which == 1) begin sel1 = sel; gut1 = gut; end
    else begin sel0 = sel; gut0 = gut; end
    set_start(which, 1'b1);
    @(negedge clk);
    // Gate selection changes after acceptance must not matter.
    if (which == 1) sel1 = sel ^ 3'b101; else sel0 = sel ^ 3'b101;
    check("busy_after_accept", int'(o_busy), 1);
    for (int c = 1; c <= exp_done + 3; c++) begin
      set_start(which, (c == restart_cyc) ? 1'b1 : 1'b0);
      if (c <= 4 * (settle + 1) && int'({o_a, o_b}) != (c - 1) / (settle + 1)) ab_bad++;
      if (o_done) begin
        done_n++;
        if (done_n == 1) done_cyc = c;
      end
      if (c == exp_done) begin
        check("pass", int'(o_pass), exp_pass);
        check("err_count", int'(o_err), exp_err);
        check("fail_mask", int'(o_mask), exp_mask);
        check("busy_in_done", int'(o_busy), 1);
      end
      if (c == exp_done + 1) check("busy_after_done", int'(o_busy), 0);
      @(negedge clk);
    end
    check("ab_sequence_errors", ab_bad, 0);
    check("done_pulses", done_n, 1);
    check("done_cycle", done_cyc, exp_done);
    check("hold_err_count", int'(o_err), exp_err);
    check("hold_fail_mask", int'(o_mask), exp_mask);
  endtask

  typedef struct {
    int         which;
    logic [2:0] sel;
    logic [3:0] gut;
    int         exp_pass;
    int         exp_err;
    int         exp_mask;
    int         restart;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{0, 3'd5, 4'b1001, 1, 0, 4'b0000, 0};  // correct XNOR
    tbl[1] = '{0, 3'd5, 4'b0110, 0, 4, 4'b1111, 0};  // XOR wired in place of XNOR
    tbl[2] = '{0, 3'd0, 4'b0000, 0, 1, 4'b1000, 0};  // AND with output stuck low
    tbl[3] = '{0, 3'd5, 4'b1001, 1, 0, 4'b0000, 5};  // start re-pulsed mid-run
    tbl[4] = '{1, 3'd7, 4'b0011, 1, 0, 4'b0000, 0};  // correct inverter, settle 1
    tbl[5] = '{0, 3'd1, 4'b1110, 1, 0, 4'b0000, 0};
    tbl[6] = '{0, 3'd6, 4'b0011, 0, 4, 4'b1111, 0};
    tbl[7] = '{1, 3'd2, 4'b0111, 1, 0, 4'b0000, 0};
    tbl[8] = '{0, 3'd3, 4'b1111, 0, 3, 4'b1110, 0};
    tbl[9] = '{1, 3'd4, 4'b0000, 0, 2, 4'b0110, 0};

    repeat (2) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      cur = w;
      #1;
      check("rst_a", int'(o_a), 0);         check("rst_b", int'(o_b), 0);
      check("rst_busy", int'(o_busy), 0);   check("rst_done", int'(o_done), 0);
      check("rst_pass", int'(o_pass), 0);   check("rst_err", int'(o_err), 0);
      check("rst_mask", int'(o_mask), 0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      run(tbl[i].which, tbl[i].sel, tbl[i].gut, tbl[i].exp_pass,
          tbl[i].exp_err, tbl[i].exp_mask, tbl[i].restart);

    // Randomized gates with arbitrary faulty truth tables.
    for (int i = 0; i < 16; i++) begin
      logic [2:0] s;
      logic [3:0] g, m;
      int         w;
      s = 3'($urandom_range(0, 7));
      g = 4'($urandom_range(0, 15));
      w = int'($urandom_range(0, 1));
      m = truth(s) ^ g;
      run(w, s, g, (m == 4'd0) ? 1 : 0, popcount(m), int'(m), 0);
    end

    // Reset in cycle 7 of a run aborts it with no done pulse.
    begin
      int done_n = 0;
      cur = 0;
      @(negedge clk);
      sel0 = 3'd4; gut0 = 4'b0110; start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      for (int c = 1; c < 7; c++) begin
        if (done0) done_n++;
        @(negedge clk);
      end
      rst = 1'b1;
      #1;
      check("abort_a", int'(a0), 0);       check("abort_b", int'(b0), 0);
      check("abort_busy", int'(busy0), 0); check("abort_done", int'(done0), 0);
      check("abort_pass", int'(pass0), 0); check("abort_err", int'(err0), 0);
      check("abort_mask", int'(mask0), 0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 16; c++) begin
        if (done0) done_n++;
        @(negedge clk);
      end
      check("abort_done_pulses", done_n, 0);
      run(0, 3'd4, 4'b0110, 1, 0, 4'b0000, 0);
    end

    // start held high through DONE launches the next run straight from IDLE.
    begin
      int first = 0, second = 0;
      cur = 0;
      @(negedge clk);
      sel0 = 3'd0; gut0 = 4'b1000; start0 = 1'b1;
      @(negedge clk);
      for (int c = 1; c <= 40 && second == 0; c++) begin
        if (done0) begin
          if (first == 0) first = c;
          else begin second = c; start0 = 1'b0; end
        end
        @(negedge clk);
      end
      start0 = 1'b0;
      check("held_start_first_done", first, 13);
      check("held_start_second_done", second, 27);
      for (int c = 0; c < 30 && busy0; c++) @(negedge clk);
      check("held_start_idle", int'(busy0), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gate_truth_checker.md
GATE_TRUTH_CHECKER -- requirements
Module: gate_truth_checker

Interface
REQ-001 Parameter SETTLE_CYC, default 2, sets the cycles each vector is held before sampling; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request one truth-table run; sampled only in IDLE.
REQ-005 gate_sel  input  3  expected function: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 BUF_A (f=a), 7 NOT_A (f=~a).
REQ-006 a  output  1  stimulus operand A to the gate under test.
REQ-007 b  output  1  stimulus operand B to the gate under test.
REQ-008 f  input  1  response from the gate under test.
REQ-009 busy  output  1  high from run acceptance until the DONE cycle ends.
REQ-010 done  output  1  single-cycle pulse marking the end of a run.
REQ-011 pass  output  1  high when the last completed run had zero mismatches.
REQ-012 err_count  output  3  mismatch count of the last run, 0..4.
REQ-013 fail_mask  output  4  bit i set when vector i mismatched; vector i = {a,b} = i.

Function
REQ-014 FSM states: IDLE, DRIVE, SAMPLE, DONE.
REQ-015 IDLE with start=1: latch gate_sel, clear err_count and fail_mask, set vector index to 0, go to DRIVE.
REQ-016 Vectors are applied in order 00, 01, 10, 11; a and b change only on DRIVE entry.
REQ-017 DRIVE lasts exactly SETTLE_CYC cycles, then goes to SAMPLE.
REQ-018 SAMPLE lasts one cycle; f is compared on the edge that ends SAMPLE against the reference value for the latched gate_sel and the current {a,b}.
REQ-019 On mismatch, set fail_mask[index] and increment err_count in the same edge.
REQ-020 From SAMPLE, go to DRIVE with index+1 when index<3; when index=3, go to DONE.
REQ-021 DONE lasts one cycle with done=1, then goes to IDLE; pass = (fail_mask==0) is registered on DONE entry.
REQ-022 Latency: done is high during cycle 4*(SETTLE_CYC+1)+1 counted from the start-accept edge (cycle 13 at SETTLE_CYC=2).
REQ-023 start is ignored while busy=1; start held high in IDLE after DONE begins a new run.
REQ-024 Changes to gate_sel during a run have no effect.
REQ-025 pass, err_count and fail_mask hold their values in IDLE until the next accepted start.
REQ-026 The index counter does not wrap; the run ends after exactly four compares.
REQ-027 All outputs are registered; f has no combinational path to any output.

Reset
REQ-028 While rst=1, state = IDLE, a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_mask=0, index=0, settle counter=0.
REQ-029 rst asserted mid-run aborts the run immediately without a done pulse; the first start after release begins a fresh run.

Structure
REQ-030 Shared package gate_chk_pkg holds the gate_sel encodings, the FSM state type and the vector-count constant (4).
REQ-031 Combinational sub-module gate_ref_model (inputs sel, a, b; output expected) computes the reference value; the FSM instantiates it once.

Verification
REQ-032 sel=5 with a correct XNOR gate, SETTLE_CYC=2 -> done in cycle 13, pass=1, err_count=0, fail_mask=0000.
REQ-033 sel=5 with an XOR gate connected -> pass=0, err_count=4, fail_mask=1111.
REQ-034 sel=0 with f stuck at 0 -> pass=0, err_count=1, fail_mask=1000.
REQ-035 start pulsed again in cycle 5 of a run -> no restart; done still in cycle 13; exactly one done pulse.
REQ-036 rst asserted in cycle 7 of a run -> all outputs at reset values within the same cycle; no done pulse; next start yields a correct full run.
REQ-037 SETTLE_CYC=1 with sel=7 and a correct inverter -> done in cycle 9, pass=1; a/b sequence 00, 01, 10, 11, each held 2 cycles.
